// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the regfile write port between writeback and buffered load returns.
// Optional WB_ARB_STATS_EN adds drain-cycle and load-buffer push statistics counters.
module wb_port_arbiter #(
   parameter int IALU_WORD_WIDTH = 16,
   parameter int REG_IDX_WIDTH   = 4,
   parameter int LD_FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT    = 4,
   parameter int STARVE_W        = 3
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       pipe_valid,
   input  logic [REG_IDX_WIDTH-1:0]   pipe_reg_idx,
   input  logic [IALU_WORD_WIDTH-1:0] pipe_res,
   output logic                       pipe_stall,
   input  logic                       ld_valid,
   input  logic [REG_IDX_WIDTH-1:0]   ld_reg_idx,
   input  logic [IALU_WORD_WIDTH-1:0] ld_data,
   output logic                       ld_ready,
   output logic                       rf_we,
   output logic [REG_IDX_WIDTH-1:0]   rf_idx,
   output logic [IALU_WORD_WIDTH-1:0] rf_data
`ifdef WB_ARB_STATS_EN
   ,
   output logic [15:0]                stat_stall_cnt,
   output logic [15:0]                stat_ld_buf_cnt
`endif
);
   localparam int PW = $clog2(LD_FIFO_DEPTH);
   localparam int CW = $clog2(LD_FIFO_DEPTH + 1);
   localparam int EW = REG_IDX_WIDTH + IALU_WORD_WIDTH;
   localparam logic [CW-1:0] FULL = CW'(LD_FIFO_DEPTH);
   localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);
   typedef enum logic {NORMAL, DRAIN} state_t;
   state_t state_q, state_d;
   logic [EW-1:0] mem_q [LD_FIFO_DEPTH];
   logic [PW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic empty, drain, grant_pipe, grant_fifo, grant_ld, push, grant;
   logic [EW-1:0] win;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= NORMAL;
      else state_q <= state_d;
   end
   // Leave DRAIN only once the buffer is fully emptied, so a drain never half-finishes.
   always_comb begin
      state_d = state_q == DRAIN ? (cnt_d == '0 ? NORMAL : DRAIN)
                                 : (starve_d == LIMIT ? DRAIN : NORMAL);
   end
   always_comb begin
      pipe_stall = state_q == DRAIN;
      ld_ready   = cnt_q != FULL;
   end
   // A buffered load always goes before a new one, so direct bypass needs an empty buffer.
   always_comb begin
      empty      = cnt_q == '0;
      drain      = state_q == DRAIN;
      grant_pipe = !drain && pipe_valid;
      grant_fifo = !grant_pipe && !empty;
      grant_ld   = !grant_pipe && empty && ld_valid;
      push       = ld_valid && ld_ready && !grant_ld;
      grant      = grant_pipe || grant_fifo || grant_ld;
      win        = grant_pipe ? {pipe_reg_idx, pipe_res}
                 : grant_fifo ? mem_q[rptr_q] : {ld_reg_idx, ld_data};
      cnt_d      = cnt_q + CW'(push) - CW'(grant_fifo);
      starve_d   = (empty || grant_fifo) ? '0 : starve_q + 1'b1;
   end
   always_ff @(posedge clock) begin
      if (push) mem_q[wptr_q] <= {ld_reg_idx, ld_data};
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         starve_q <= '0;
         rf_we    <= 1'b0;
         rf_idx   <= '0;
         rf_data  <= '0;
      end else begin
         cnt_q    <= cnt_d;
         wptr_q   <= push ? wptr_q + 1'b1 : wptr_q;
         rptr_q   <= grant_fifo ? rptr_q + 1'b1 : rptr_q;
         starve_q <= starve_d;
         rf_we    <= grant;
         if (grant) {rf_idx, rf_data} <= win;
      end
   end
`ifdef WB_ARB_STATS_EN
   logic [15:0] stall_cnt_q, buf_cnt_q;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         buf_cnt_q   <= '0;
      end else begin
         if (drain && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 1'b1;
         if (push && buf_cnt_q != 16'hFFFF) buf_cnt_q <= buf_cnt_q + 1'b1;
      end
   end
   assign stat_stall_cnt  = stall_cnt_q;
   assign stat_ld_buf_cnt = buf_cnt_q;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_wb_port_arbiter;
   localparam int DW = 16, IW = 4, DEPTH = 2, LIMIT = 4;
   logic clock = 1'b0, reset = 1'b1;
   logic pipe_valid = 1'b0, ld_valid = 1'b0;
   logic [IW-1:0] pipe_reg_idx = '0, ld_reg_idx = '0;
   logic [DW-1:0] pipe_res = '0, ld_data = '0;
   logic pipe_stall, ld_ready, rf_we;
   logic [IW-1:0] rf_idx;
   logic [DW-1:0] rf_data;
`ifdef WB_ARB_STATS_EN
   logic [15:0] stat_stall_cnt, stat_ld_buf_cnt;
`endif
   int total = 0, bad = 0;
   logic [IW+DW-1:0] q[$];
   int starve;
   bit drain;
   logic exp_we;
   logic [IW-1:0] exp_idx;
   logic [DW-1:0] exp_data;

   wb_port_arbiter dut (
      .clock(clock), .reset(reset),
      .pipe_valid(pipe_valid), .pipe_reg_idx(pipe_reg_idx), .pipe_res(pipe_res),
      .pipe_stall(pipe_stall),
      .ld_valid(ld_valid), .ld_reg_idx(ld_reg_idx), .ld_data(ld_data), .ld_ready(ld_ready),
      .rf_we(rf_we), .rf_idx(rf_idx), .rf_data(rf_data)
`ifdef WB_ARB_STATS_EN
      , .stat_stall_cnt(stat_stall_cnt), .stat_ld_buf_cnt(stat_ld_buf_cnt)
`endif
   );

   always #5 clock = ~clock;

   task automatic model_clear();
      q.delete();
      starve = 0;
      drain = 0;
      exp_we = 0;
      exp_idx = '0;
      exp_data = '0;
   endtask

   // One clock edge of the arbitration rules, applied to the inputs currently driven.
   task automatic model_edge();
      bit had, popped, direct, acc;
      logic [IW+DW-1:0] e;
      had = q.size() > 0;
      acc = ld_valid && q.size() < DEPTH;
      popped = 0;
      direct = 0;
      exp_we = 1;
      if (!drain && pipe_valid) {exp_idx, exp_data} = {pipe_reg_idx, pipe_res};
      else if (had) begin
         e = q.pop_front();
         {exp_idx, exp_data} = e;
         popped = 1;
      end else if (ld_valid) begin
         {exp_idx, exp_data} = {ld_reg_idx, ld_data};
         direct = 1;
      end else exp_we = 0;
      if (acc && !direct) q.push_back({ld_reg_idx, ld_data});
      starve = (!had || popped) ? 0 : starve + 1;
      if (drain) drain = q.size() != 0;
      else drain = starve == LIMIT;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      pipe_valid = 0;
      ld_valid = 0;
      pipe_reg_idx = '0;
      pipe_res = '0;
      ld_reg_idx = '0;
      ld_data = '0;
   endtask

   task automatic do_reset();
      reset = 1;
      clear_inputs();
      model_clear();
      @(posedge clock);
      #1;
      reset = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      clear_inputs();
      #2;
      total += 5;
      if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", rf_we); end
      if (rf_idx !== '0) begin bad++; $display("FAIL reset_idx got=%h want=0", rf_idx); end
      if (rf_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", rf_data); end
      if (pipe_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", pipe_stall); end
      if (ld_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ld_ready); end
      @(posedge clock);
      #1;
      reset = 0;
      model_clear();
   endtask

   task automatic test_pipe_only();
      do_reset();
      pipe_valid = 1; pipe_reg_idx = 4'd3; pipe_res = 16'h1234;
      tick();
      pipe_valid = 0;
      total += 3;
      if (rf_we !== 1'b1) begin bad++; $display("FAIL pipe_we got=%b want=1", rf_we); end
      if (rf_idx !== 4'd3) begin bad++; $display("FAIL pipe_idx got=%h want=3", rf_idx); end
      if (rf_data !== 16'h1234) begin bad++; $display("FAIL pipe_data got=%h want=1234", rf_data); end
      tick();
      total += 2;
      if (rf_we !== 1'b0) begin bad++; $display("FAIL pipe_idle_we got=%b want=0", rf_we); end
      if (rf_data !== 16'h1234) begin bad++; $display("FAIL pipe_hold_data got=%h want=1234", rf_data); end
   endtask

   task automatic test_load_direct();
      do_reset();
      ld_valid = 1; ld_reg_idx = 4'd5; ld_data = 16'hBEEF;
      tick();
      ld_valid = 0;
      total += 4;
      if (rf_we !== 1'b1) begin bad++; $display("FAIL ld_we got=%b want=1", rf_we); end
      if (rf_idx !== 4'd5) begin bad++; $display("FAIL ld_idx got=%h want=5", rf_idx); end
      if (rf_data !== 16'hBEEF) begin bad++; $display("FAIL ld_data got=%h want=beef", rf_data); end
      if (pipe_stall !== 1'b0) begin bad++; $display("FAIL ld_stall got=%b want=0", pipe_stall); end
      tick();
      total++;
      if (rf_we !== 1'b0) begin bad++; $display("FAIL ld_nobuf_we got=%b want=0", rf_we); end
   endtask

   task automatic test_collision();
      do_reset();
      pipe_valid = 1; pipe_reg_idx = 4'd1; pipe_res = 16'h1111;
      ld_valid = 1; ld_reg_idx = 4'd2; ld_data = 16'h2222;
      tick();
      clear_inputs();
      total += 2;
      if (rf_idx !== 4'd1) begin bad++; $display("FAIL coll_first_idx got=%h want=1", rf_idx); end
      if (rf_data !== 16'h1111) begin bad++; $display("FAIL coll_first_data got=%h want=1111", rf_data); end
      tick();
      total += 3;
      if (rf_we !== 1'b1) begin bad++; $display("FAIL coll_second_we got=%b want=1", rf_we); end
      if (rf_idx !== 4'd2) begin bad++; $display("FAIL coll_second_idx got=%h want=2", rf_idx); end
      if (rf_data !== 16'h2222) begin bad++; $display("FAIL coll_second_data got=%h want=2222", rf_data); end
      tick();
      total++;
      if (rf_we !== 1'b0) begin bad++; $display("FAIL coll_empty_we got=%b want=0", rf_we); end
   endtask

   task automatic test_starve();
      do_reset();
      pipe_valid = 1; pipe_reg_idx = 4'd7; pipe_res = 16'h7777;
      ld_valid = 1; ld_reg_idx = 4'd9; ld_data = 16'hABCD;
      tick();
      ld_valid = 0;
      for (int i = 1; i <= LIMIT; i++) begin
         total++;
         if (pipe_stall !== 1'b0) begin bad++; $display("FAIL starve_wait%0d_stall got=%b want=0", i, pipe_stall); end
         tick();
         total++;
         if (rf_idx !== 4'd7) begin bad++; $display("FAIL starve_wait%0d_idx got=%h want=7", i, rf_idx); end
      end
      total++;
      if (pipe_stall !== 1'b1) begin bad++; $display("FAIL starve_drain_stall got=%b want=1", pipe_stall); end
      tick();
      total += 3;
      if (rf_idx !== 4'd9) begin bad++; $display("FAIL starve_load_idx got=%h want=9", rf_idx); end
      if (rf_data !== 16'hABCD) begin bad++; $display("FAIL starve_load_data got=%h want=abcd", rf_data); end
      if (pipe_stall !== 1'b0) begin bad++; $display("FAIL starve_release got=%b want=0", pipe_stall); end
      tick();
      pipe_valid = 0;
      total++;
      if (rf_idx !== 4'd7) begin bad++; $display("FAIL starve_pipe_resume got=%h want=7", rf_idx); end
   endtask

   task automatic test_full();
      int n;
      do_reset();
      pipe_valid = 1; pipe_reg_idx = 4'd1; pipe_res = 16'h0101;
      ld_valid = 1; ld_reg_idx = 4'd2; ld_data = 16'h0202;
      tick();
      ld_reg_idx = 4'd3; ld_data = 16'h0303;
      tick();
      total++;
      if (ld_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", ld_ready); end
      ld_reg_idx = 4'd4; ld_data = 16'h0404;
      n = 0;
      while (!ld_ready && n < 20) begin
         tick();
         n++;
      end
      total++;
      if (n != 4) begin bad++; $display("FAIL full_wait_cycles got=%0d want=4", n); end
      tick();
      clear_inputs();
      total++;
      if (rf_idx !== 4'd3) begin bad++; $display("FAIL full_order2_idx got=%h want=3", rf_idx); end
      tick();
      total += 3;
      if (rf_idx !== 4'd4) begin bad++; $display("FAIL full_order3_idx got=%h want=4", rf_idx); end
      if (pipe_stall !== 1'b0) begin bad++; $display("FAIL full_release got=%b want=0", pipe_stall); end
      if (ld_ready !== 1'b1) begin bad++; $display("FAIL full_empty_ready got=%b want=1", ld_ready); end
   endtask

   task automatic test_reset_mid();
      int n;
      do_reset();
      pipe_valid = 1; pipe_reg_idx = 4'd6; pipe_res = 16'h6666;
      ld_valid = 1; ld_reg_idx = 4'd8; ld_data = 16'h8888;
      tick();
      ld_reg_idx = 4'd10;
      tick();
      ld_valid = 0;
      n = 0;
      while (!pipe_stall && n < 10) begin
         tick();
         n++;
      end
      total += 2;
      if (pipe_stall !== 1'b1) begin bad++; $display("FAIL mid_drain_reached got=%b want=1", pipe_stall); end
      if (ld_ready !== 1'b0) begin bad++; $display("FAIL mid_full got=%b want=0", ld_ready); end
      #2;
      reset = 1;
      #1;
      total += 4;
      if (rf_we !== 1'b0) begin bad++; $display("FAIL mid_rst_we got=%b want=0", rf_we); end
      if (pipe_stall !== 1'b0) begin bad++; $display("FAIL mid_rst_stall got=%b want=0", pipe_stall); end
      if (ld_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b want=1", ld_ready); end
      if (rf_idx !== '0) begin bad++; $display("FAIL mid_rst_idx got=%h want=0", rf_idx); end
      clear_inputs();
      model_clear();
      @(posedge clock);
      #1;
      reset = 0;
      tick();
      total++;
      if (rf_we !== 1'b0) begin bad++; $display("FAIL mid_rst_fifo_dropped got=%b want=0", rf_we); end
   endtask

   task automatic test_random();
      int drains;
      do_reset();
      drains = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!drain) begin
            pipe_valid = $urandom_range(0, 3) != 0;
            pipe_reg_idx = IW'($urandom);
            pipe_res = DW'($urandom);
         end
         ld_valid = $urandom_range(0, 2) == 0;
         ld_reg_idx = IW'($urandom);
         ld_data = DW'($urandom);
         if (drain) drains++;
         total += 2;
         if (pipe_stall !== drain) begin bad++; $display("FAIL rand_stall c=%0d got=%b want=%b", c, pipe_stall, drain); end
         if (ld_ready !== (q.size() < DEPTH)) begin bad++; $display("FAIL rand_ready c=%0d got=%b want=%b", c, ld_ready, q.size() < DEPTH); end
         tick();
         total += 3;
         if (rf_we !== exp_we) begin bad++; $display("FAIL rand_we c=%0d got=%b want=%b", c, rf_we, exp_we); end
         if (rf_idx !== exp_idx) begin bad++; $display("FAIL rand_idx c=%0d got=%h want=%h", c, rf_idx, exp_idx); end
         if (rf_data !== exp_data) begin bad++; $display("FAIL rand_data c=%0d got=%h want=%h", c, rf_data, exp_data); end
      end
      clear_inputs();
      total++;
      if (drains == 0) begin bad++; $display("FAIL rand_drain_seen got=0 want>0"); end
   endtask

   initial begin
      test_reset();
      test_pipe_only();
      test_load_direct();
      test_collision();
      test_starve();
      test_full();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
